// File: rtl/mii_tx_framer.sv
// MII transmit framer: wraps a byte stream in preamble, SFD, fixed MAC header,
// zero padding and CRC-32 FCS, then holds off for the inter-frame gap.
module mii_tx_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0010_A4C0_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned IFG_NIBBLES = 24,
    parameter int unsigned LEN_W       = 11
) (
    input  logic       phy_txclk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] phy_txd,
    output logic       phy_txen,
    output logic       phy_txer,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [111:0]     HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [31:0]      CRC_POLY = 32'hEDB8_8320;
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] SFD_PREV = CNT_W'(14);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(27);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(7);
    // The IDLE handshake cycle completes the gap, so IFG itself is one shorter.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_DATA, S_PAD, S_FCS, S_IFG, S_ABORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic [7:0]       data_q;
    logic             last_q;
    logic             hi;
    logic [31:0]      crc;
    logic [31:0]      crc_upd;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [3:0] hdr_nib(input logic [4:0] n);
        logic [7:0] b;
        b = 8'(HDR >> (7'd104 - {n[4:1], 3'b000}));
        return n[0] ? b[7:4] : b[3:0];
    endfunction

    // CRC including the nibble currently on the wire
    always_comb crc_upd = crc_nib(crc, phy_txd);

    always_ff @(posedge phy_txclk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len        <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            hi         <= 1'b0;
            crc        <= '0;
            in_ready   <= 1'b0;
            phy_txd    <= '0;
            phy_txen   <= 1'b0;
            phy_txer   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (state inside {S_HDR, S_DATA, S_PAD})
                crc <= crc_upd;
            case (state)
                S_IDLE: begin
                    in_ready <= in_valid;
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        last_q   <= in_last;
                        len      <= LEN_W'(1);
                        crc      <= 32'hFFFF_FFFF;
                        cnt      <= '0;
                        state    <= S_PRE;
                        busy     <= 1'b1;
                        phy_txen <= 1'b1;
                        phy_txd  <= 4'h5;
                        in_ready <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state   <= S_HDR;
                        cnt     <= '0;
                        phy_txd <= hdr_nib(5'd0);
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        phy_txd <= (cnt == SFD_PREV) ? 4'hD : 4'h5;
                    end
                end
                S_HDR: begin
                    if (cnt == HDR_LAST) begin
                        state   <= S_DATA;
                        hi      <= 1'b0;
                        phy_txd <= data_q[3:0];
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        phy_txd <= hdr_nib(5'(cnt + CNT_W'(1)));
                    end
                end
                S_DATA: begin
                    if (!hi) begin
                        hi       <= 1'b1;
                        phy_txd  <= data_q[7:4];
                        in_ready <= !last_q;
                    end else if (last_q) begin
                        if (len < MIN_LEN) begin
                            state   <= S_PAD;
                            hi      <= 1'b0;
                            phy_txd <= 4'h0;
                        end else begin
                            state   <= S_FCS;
                            cnt     <= '0;
                            phy_txd <= ~crc_upd[3:0];
                        end
                    end else if (!in_valid || len == MAX_LEN) begin
                        // Underrun, or the oversize byte was just consumed
                        state     <= S_ABORT;
                        cnt       <= '0;
                        phy_txer  <= 1'b1;
                        phy_txd   <= 4'h0;
                        frame_err <= 1'b1;
                        in_ready  <= 1'b0;
                    end else begin
                        data_q   <= in_data;
                        last_q   <= in_last;
                        len      <= len + LEN_W'(1);
                        hi       <= 1'b0;
                        phy_txd  <= in_data[3:0];
                        in_ready <= 1'b0;
                    end
                end
                S_PAD: begin
                    if (!hi) begin
                        hi <= 1'b1;
                    end else if (len + LEN_W'(1) == MIN_LEN) begin
                        state   <= S_FCS;
                        cnt     <= '0;
                        phy_txd <= ~crc_upd[3:0];
                    end else begin
                        len <= len + LEN_W'(1);
                        hi  <= 1'b0;
                    end
                end
                S_FCS: begin
                    if (cnt == FCS_LAST) begin
                        state      <= S_IFG;
                        cnt        <= '0;
                        phy_txen   <= 1'b0;
                        phy_txd    <= 4'h0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        crc     <= crc >> 4;
                        phy_txd <= ~crc[7:4];
                    end
                end
                S_ABORT: begin
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state    <= S_IFG;
                        cnt      <= '0;
                        phy_txen <= 1'b0;
                        phy_txer <= 1'b0;
                    end
                end
                S_IFG: begin
                    if (cnt == IFG_LAST) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        in_ready <= in_valid;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
Parametrised MII transmit framer for 10/100 Ethernet, running entirely in the phy_txclk domain.
- Accepts a byte stream over a valid/ready handshake.
- Prepends preamble, SFD and a parameter-configured MAC header.
- Pads short payloads and appends a CRC-32 FCS computed in-block.
- Enforces the inter-frame gap.
- Adds underrun/oversize abort signalling on phy_txer and per-frame status pulses.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination address; first header byte is DST_MAC[47:40].
SRC_MAC, 48'h0010_A4C0_0001, source address; byte order as DST_MAC.
ETHERTYPE, 16'h0800, type/length field; [15:8] sent first.
MIN_PAYLOAD, 46, payload bytes below which zero padding is added.
MAX_PAYLOAD, 1500, payload byte limit; longer input aborts the frame.
IFG_NIBBLES, 24, idle nibble times after each frame (96 bit times).
LEN_W, 11, payload counter width; 2^LEN_W must exceed MAX_PAYLOAD.

Ports:
phy_txclk  in  1  MII TX clock (2.5/25 MHz); sole clock, rising edge.
reset  in  1  asynchronous, active-high.
in_data  in  8  payload byte.
in_valid  in  1  in_data valid.
in_last  in  1  marks final payload byte; qualified by in_valid.
in_ready  out  1  byte accepted when in_valid && in_ready.
phy_txd  out  4  MII nibble, low nibble of each byte first.
phy_txen  out  1  MII transmit enable.
phy_txer  out  1  MII transmit error.
busy  out  1  high from frame start until IFG complete.
frame_done  out  1  one-cycle pulse: good frame completed (last FCS nibble sent).
frame_err  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (async): all outputs 0; state IDLE; IFG counter cleared, so a frame may start right after reset release.
- All outputs are registered; each nibble below occupies exactly one phy_txclk cycle.
- States: IDLE -> PRE -> HDR -> DATA -> PAD -> FCS -> IFG -> IDLE; ABORT -> IFG.
- IDLE:
  - in_ready = in_valid.
  - On handshake: latch first byte, clear CRC to 32'hFFFF_FFFF, go to PRE.
  - phy_txen rises on the next cycle.
- PRE: 15 nibbles 4'h5, then 4'hD (SFD); 16 cycles total. CRC not updated.
- HDR: 28 nibbles (DST_MAC, SRC_MAC, ETHERTYPE) in byte order given; within each byte, low nibble first. CRC updated.
- DATA:
  - Sends latched byte: low nibble, then high nibble.
  - in_ready is high only on the high-nibble cycle, and only if the latched byte was not last.
  - At that handshake the next byte is latched.
  - After the last byte: go to PAD if byte count < MIN_PAYLOAD, else FCS.
- Underrun: in_valid=0 while in_ready=1 in DATA -> ABORT.
- Oversize: handshake of byte MAX_PAYLOAD+1 -> ABORT; that byte is consumed and discarded.
- PAD: zero nibbles until payload+pad = MIN_PAYLOAD bytes. CRC updated.
- FCS:
  - CRC is IEEE 802.3 CRC-32: reflected, poly 0x04C11DB7, nibble-serial, LSB first.
  - Transmit ~CRC over 8 nibbles, bits [3:0] first.
  - frame_done pulses on the cycle after the last FCS nibble; phy_txen falls that cycle.
- ABORT:
  - 2 cycles with phy_txen=1, phy_txer=1, phy_txd=0.
  - frame_err pulses on the first ABORT cycle.
  - The remaining input bytes of that frame are not consumed by the block; upstream flushes.
- IFG: phy_txen=0 for exactly IFG_NIBBLES cycles; in_ready=0; then IDLE.
- busy: 0 only in IDLE.
- phy_txer: 0 outside ABORT.
- phy_txd: 0 whenever phy_txen=0.
- in_last on the first byte means a 1-byte payload, which is padded.
- Minimum frame: 16+28+2*MIN_PAYLOAD+8 = 144 txen cycles at defaults.
- Reset asserted mid-frame: phy_txen drops immediately (async); no status pulse.

Test Plan:
- 46-byte payload 0x00..0x2D, in_valid held: phy_txen high 144 cycles; nibbles 5,5,...,5,D then F,F (DST byte 0); frame_done once; no PAD cycles.
- 1-byte payload 0xA5 with in_last: txd data nibbles 5 then A, then 90 zero nibbles, 8 FCS nibbles; receiver-side CRC over dest..FCS gives residue 32'hC704DD7B.
- Two back-to-back 60-byte payloads, in_valid always high: exactly 24 cycles with phy_txen=0 between frames; second preamble begins on cycle 25.
- Drop in_valid at the 10th byte request: phy_txer=1 for 2 cycles with txen=1, frame_err pulse, then 24-cycle IFG; no frame_done.
- MAX_PAYLOAD=64 and 70-byte input: abort on the 65th handshake, frame_err=1, 65 bytes consumed.
- Assert reset at cycle 50 of a frame: phy_txen, in_ready and busy go 0 without a clock edge; after release, a new frame starts with a full preamble.
